configs_loader: RTL
===================

# configs_loader

Parametrised, flip-flop based configuration store that replaces the per-word transparent latch bank with a sequenced loader. Accepts a stream of configuration words over a valid/ready handshake and writes them into NUM_WORDS registers in ascending order. Adds readback, a running XOR checksum, abort and a done indication. Sits between the tile's configuration shift/bus interface and the LUT/routing configuration bits of the tile.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one configuration word
- NUM_WORDS, 9, number of configuration words; must be at least 2
- ADDR_WIDTH, 4, word address width; must satisfy 2^ADDR_WIDTH >= NUM_WORDS

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- io_start  in  1  begin a load sequence at word 0
- io_abort  in  1  abandon the current load sequence
- io_d_in  in  DATA_WIDTH  configuration word
- io_d_valid  in  1  io_d_in is valid
- io_d_ready  out  1  loader accepts a word this cycle
- io_configs_out  out  DATA_WIDTH*NUM_WORDS  word k on bits [k*DATA_WIDTH +: DATA_WIDTH]
- io_busy  out  1  high in LOAD
- io_done  out  1  high in DONE
- io_wr_addr  out  ADDR_WIDTH  index of the next word to be written
- io_checksum  out  DATA_WIDTH  XOR of all words accepted since the last start
- io_rd_addr  in  ADDR_WIDTH  readback word index
- io_rd_data  out  DATA_WIDTH  registered readback data

## Operation
- FSM states: IDLE, LOAD, DONE. All outputs are registered or decoded directly from the state.
- IDLE: io_d_ready=0. io_start=1 -> LOAD, wr_addr=0, checksum=0.
- LOAD: io_d_ready=1, io_busy=1. A handshake (valid & ready) writes io_d_in to word[wr_addr], checksum ^= io_d_in, and increments wr_addr. A handshake at wr_addr==NUM_WORDS-1 moves to DONE; wr_addr wraps to 0.
- DONE: io_done=1, io_d_ready=0. io_start=1 -> LOAD (full reload, checksum cleared). The configuration words are held.
- io_abort in LOAD -> IDLE. Already written words are retained, and wr_addr and the checksum are frozen. io_abort in IDLE or DONE has no effect.
- Simultaneous io_start and io_abort: abort wins. io_start during LOAD is ignored.
- A handshake in the same cycle as io_abort is discarded: no write and no checksum update.
- Configuration words change only via a handshake or reset. Partial reloads keep the old contents in unwritten words.
- Readback: io_rd_data <= word[io_rd_addr] every cycle. If io_rd_addr >= NUM_WORDS, io_rd_data <= 0.

## Timing
- Reset (synchronous): state=IDLE. All config words, io_checksum, io_wr_addr and io_rd_data are 0. io_busy, io_done and io_d_ready are 0. Reset overrides start/abort/handshake in the same cycle.
- io_start sampled at edge N -> io_busy and io_d_ready high after edge N. The first word can be accepted at edge N+1.
- Throughput: one word per cycle while io_d_valid is held high. A full load takes NUM_WORDS accepting cycles.
- A word written at edge N is visible on io_configs_out and io_checksum after edge N.
- io_done rises after the edge that accepts the last word. io_d_ready is low in that following cycle.
- Readback latency: 1 cycle. A read of a word written at the same edge returns the old value.

## Test plan
- Reset, then start, then 9 back-to-back words 0x1..0x9 -> io_configs_out word k = k+1; io_checksum=0x1; io_done=1 after edge 9; io_d_ready=0 afterwards.
- Same load with io_d_valid toggling every other cycle -> identical final contents; io_wr_addr increments only on handshakes.
- Abort after 4 words (0xA0..0xA3) into a prior full load of 0xFF.. -> words 0-3 = 0xA0..0xA3, words 4-8 keep the old value; state IDLE; io_wr_addr=4.
- io_start and io_abort both high in LOAD -> state IDLE. Also: io_start during LOAD -> no restart, io_wr_addr unchanged.
- Readback: io_rd_addr=3 -> the word 3 value one cycle later. io_rd_addr=12 -> 0. Same-edge write and read of word 5 -> old value, then the new value the next cycle.
- Assert reset mid-load (after 2 words) with io_d_valid high -> all words, checksum and flags are 0 next cycle; io_d_ready=0.

Source files
------------

// File: rtl/configs_loader.sv
// Sequenced configuration store: accepts a stream of words over valid/ready and
// writes them in ascending order into NUM_WORDS registers, with readback and an XOR checksum.
module configs_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            io_start,
  input  logic                            io_abort,
  input  logic [DATA_WIDTH-1:0]           io_d_in,
  input  logic                            io_d_valid,
  output logic                            io_d_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] io_configs_out,
  output logic                            io_busy,
  output logic                            io_done,
  output logic [ADDR_WIDTH-1:0]           io_wr_addr,
  output logic [DATA_WIDTH-1:0]           io_checksum,
  input  logic [ADDR_WIDTH-1:0]           io_rd_addr,
  output logic [DATA_WIDTH-1:0]           io_rd_data
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_WORDS_EXT = (ADDR_WIDTH + 1)'(NUM_WORDS);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   words_q [NUM_WORDS];
  logic                    wr_en;

  assign io_d_ready  = (state_q == LOAD);
  assign io_busy     = (state_q == LOAD);
  assign io_done     = (state_q == DONE);
  assign io_wr_addr  = wr_addr_q;
  assign io_checksum = checksum_q;
  assign io_rd_data  = rd_data_q;

  // Abort takes priority over both start and a coincident handshake.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    checksum_d = checksum_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (io_start && !io_abort) begin
          state_d    = LOAD;
          wr_addr_d  = '0;
          checksum_d = '0;
        end
      end
      LOAD: begin
        if (io_abort) begin
          state_d = IDLE;
        end else if (io_d_valid) begin
          wr_en      = 1'b1;
          checksum_d = checksum_q ^ io_d_in;
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = DONE;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, io_rd_addr} < NUM_WORDS_EXT) begin
      rd_data_d = words_q[io_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      checksum_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      checksum_q <= checksum_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (reset) begin
        words_q[k] <= '0;
      end else if (wr_en && (wr_addr_q == ADDR_WIDTH'(k))) begin
        words_q[k] <= io_d_in;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_pack
      assign io_configs_out[gi*DATA_WIDTH +: DATA_WIDTH] = words_q[gi];
    end
  endgenerate

endmodule
